// File: rtl/clock_pkg.sv
// Shared alarm-ringer types and parameter defaults.
// Holds the ring-state encoding and the saturating second-counter helper.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } ring_state_t;

    localparam int TONE_DIV_DEFAULT     = 25000;
    localparam int RING_TIMEOUT_DEFAULT = 60;
    localparam int SNOOZE_SEC_DEFAULT   = 300;
    localparam int MAX_SNOOZE_DEFAULT   = 3;

    localparam int SEC_W = 9;

    // Sticks at all-ones so a long ring or snooze can never wrap back to zero.
    function automatic logic [SEC_W-1:0] sat_inc(input logic [SEC_W-1:0] v);
        return (&v) ? v : v + SEC_W'(1);
    endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Alarm ringer control/status bundle: button and tick inputs, buzzer and state outputs.
interface alarm_ringer_if;
    import clock_pkg::*;

    logic        alarm_do;
    logic        sec_tick;
    logic        middle;
    logic        down;
    logic        buzz;
    ring_state_t ring_state;
    logic [2:0]  snooze_left;

    modport master (
        output alarm_do, sec_tick, middle, down,
        input  buzz, ring_state, snooze_left
    );

    modport slave (
        input  alarm_do, sec_tick, middle, down,
        output buzz, ring_state, snooze_left
    );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse when level is high and was low last cycle.
module edge_detect (
    input  logic newclk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic prev_reg;

    // Clearing to 0 lets a level already high at reset release count as an edge.
    always_ff @(posedge newclk) begin
        if (rst) prev_reg <= 1'b0;
        else     prev_reg <= level;
    end

    assign rise = level & ~prev_reg;
endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings on alarm edge, supports limited snoozes, auto-stops,
// and drives a 1 Hz beep-pause square-wave buzzer.
module alarm_ringer
    import clock_pkg::*;
#(
    parameter int TONE_DIV     = TONE_DIV_DEFAULT,
    parameter int RING_TIMEOUT = RING_TIMEOUT_DEFAULT,
    parameter int SNOOZE_SEC   = SNOOZE_SEC_DEFAULT,
    parameter int MAX_SNOOZE   = MAX_SNOOZE_DEFAULT
) (
    input  logic           newclk,
    input  logic           rst,
    alarm_ringer_if.slave  bus
);
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [2:0] level_vec;
    logic [2:0] rise_vec;
    logic       trig_rise;
    logic       dismiss_rise;
    logic       snooze_rise;

    ring_state_t      state_reg, state_next;
    logic [SEC_W-1:0] sec_cnt_reg, sec_cnt_next, sec_inc;
    logic [2:0]       snooze_left_reg, snooze_left_next;
    logic [TW-1:0]    tone_cnt_reg, tone_cnt_next;
    logic             buzz_reg, buzz_next;
    logic             enter_ring;

    assign level_vec = {bus.down, bus.middle, bus.alarm_do};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            edge_detect u_edge (
                .newclk (newclk),
                .rst    (rst),
                .level  (level_vec[gi]),
                .rise   (rise_vec[gi])
            );
        end
    endgenerate

    assign trig_rise    = rise_vec[0];
    assign dismiss_rise = rise_vec[1];
    assign snooze_rise  = rise_vec[2];

    always_ff @(posedge newclk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            sec_cnt_reg     <= '0;
            snooze_left_reg <= 3'(MAX_SNOOZE);
            tone_cnt_reg    <= '0;
            buzz_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sec_cnt_reg     <= sec_cnt_next;
            snooze_left_reg <= snooze_left_next;
            tone_cnt_reg    <= tone_cnt_next;
            buzz_reg        <= buzz_next;
        end
    end

    // Branch order encodes the dismiss > snooze > tick priority.
    always_comb begin
        state_next       = state_reg;
        sec_cnt_next     = sec_cnt_reg;
        snooze_left_next = snooze_left_reg;
        sec_inc          = sat_inc(sec_cnt_reg);
        case (state_reg)
            ST_IDLE: begin
                if (trig_rise) begin
                    state_next       = ST_RING;
                    sec_cnt_next     = '0;
                    snooze_left_next = 3'(MAX_SNOOZE);
                end
            end
            ST_RING: begin
                if (dismiss_rise) begin
                    state_next = ST_IDLE;
                end else if (snooze_rise && (snooze_left_reg != 3'd0)) begin
                    state_next       = ST_SNOOZE;
                    snooze_left_next = snooze_left_reg - 3'd1;
                    sec_cnt_next     = '0;
                end else if (bus.sec_tick) begin
                    sec_cnt_next = sec_inc;
                    if (sec_inc == SEC_W'(RING_TIMEOUT)) state_next = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (dismiss_rise) begin
                    state_next = ST_IDLE;
                end else if (bus.sec_tick) begin
                    if (sec_inc == SEC_W'(SNOOZE_SEC)) begin
                        state_next   = ST_RING;
                        sec_cnt_next = '0;
                    end else begin
                        sec_cnt_next = sec_inc;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tone runs only through even seconds of an established ring; the divider
    // restarts from zero on entry and during every silent odd second.
    always_comb begin
        enter_ring    = (state_next == ST_RING) && (state_reg != ST_RING);
        buzz_next     = 1'b0;
        tone_cnt_next = '0;
        if ((state_next == ST_RING) && !enter_ring && !sec_cnt_next[0]) begin
            if (tone_cnt_reg == TW'(TONE_DIV - 1)) begin
                buzz_next = ~buzz_reg;
            end else begin
                tone_cnt_next = tone_cnt_reg + TW'(1);
                buzz_next     = buzz_reg;
            end
        end
    end

    assign bus.buzz        = buzz_reg;
    assign bus.ring_state  = state_reg;
    assign bus.snooze_left = snooze_left_reg;
endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with small parameters (tone 2, timeout 5, snooze 3, max 2).
module tb_alarm_ringer;
    import clock_pkg::*;

    logic newclk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   exp_buzz [7] = '{0, 0, 1, 1, 0, 0, 1};

    alarm_ringer_if bus ();

    alarm_ringer #(
        .TONE_DIV     (2),
        .RING_TIMEOUT (5),
        .SNOOZE_SEC   (3),
        .MAX_SNOOZE   (2)
    ) dut (
        .newclk (newclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 newclk = ~newclk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Outputs are examined 1 time unit after the edge; inputs change there too.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge newclk);
            #1;
        end
    endtask

    task automatic sec_pulse();
        bus.sec_tick = 1'b1;
        cycles(1);
        bus.sec_tick = 1'b0;
    endtask

    task automatic check_state(input string tag, input int st, input int left);
        check({tag, ".state"}, int'(bus.ring_state), st);
        check({tag, ".left"}, int'(bus.snooze_left), left);
    endtask

    initial begin
        rst = 1'b1;
        bus.alarm_do = 1'b0;
        bus.sec_tick = 1'b0;
        bus.middle   = 1'b0;
        bus.down     = 1'b0;
        cycles(3);
        $display("scenario: reset");
        check_state("reset", 0, 2);
        check("reset.buzz", int'(bus.buzz), 0);
        rst = 1'b0;
        cycles(2);

        $display("scenario: alarm edge starts ring, tone pattern");
        bus.alarm_do = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycles(1);
            if (i == 0) check_state("ring_entry", 1, 2);
            check($sformatf("tone%0d", i), int'(bus.buzz), exp_buzz[i]);
        end

        $display("scenario: odd second silent, even second beeps, timeout");
        sec_pulse();
        check("tick1.buzz", int'(bus.buzz), 0);
        cycles(3);
        check("tick1.hold_buzz", int'(bus.buzz), 0);
        sec_pulse();
        check("tick2.buzz0", int'(bus.buzz), 0);
        cycles(1);
        check("tick2.buzz1", int'(bus.buzz), 1);
        cycles(2);
        sec_pulse();
        cycles(2);
        sec_pulse();
        check("tick4.state", int'(bus.ring_state), 1);
        cycles(2);
        sec_pulse();
        check("timeout.state", int'(bus.ring_state), 0);
        check("timeout.buzz", int'(bus.buzz), 0);
        cycles(4);
        check("held_alarm.state", int'(bus.ring_state), 0);
        bus.alarm_do = 1'b0;
        cycles(2);

        $display("scenario: snooze sequence until exhausted");
        bus.alarm_do = 1'b1;
        cycles(1);
        check_state("ring2", 1, 2);
        bus.down = 1'b1;
        cycles(1);
        bus.down = 1'b0;
        check_state("snooze1", 2, 1);
        check("snooze1.buzz", int'(bus.buzz), 0);
        sec_pulse();
        cycles(1);
        sec_pulse();
        check("snooze1.tick2", int'(bus.ring_state), 2);
        sec_pulse();
        check("snooze1.wake", int'(bus.ring_state), 1);
        bus.down = 1'b1;
        cycles(1);
        bus.down = 1'b0;
        check_state("snooze2", 2, 0);
        for (int i = 0; i < 3; i++) sec_pulse();
        check("snooze2.wake", int'(bus.ring_state), 1);
        bus.down = 1'b1;
        cycles(1);
        bus.down = 1'b0;
        check_state("snooze_none_left", 1, 0);
        bus.alarm_do = 1'b0;
        cycles(1);
        bus.alarm_do = 1'b1;
        cycles(1);
        check_state("retrigger_in_ring", 1, 0);
        bus.middle = 1'b1;
        cycles(1);
        bus.middle = 1'b0;
        check("dismiss.state", int'(bus.ring_state), 0);
        cycles(1);
        bus.middle = 1'b1;
        cycles(1);
        bus.middle = 1'b0;
        check("dismiss_idle.state", int'(bus.ring_state), 0);

        $display("scenario: dismiss and snooze in same cycle");
        bus.alarm_do = 1'b0;
        cycles(1);
        bus.alarm_do = 1'b1;
        cycles(1);
        check_state("ring3", 1, 2);
        bus.middle = 1'b1;
        bus.down   = 1'b1;
        cycles(1);
        bus.middle = 1'b0;
        bus.down   = 1'b0;
        check_state("both_buttons", 0, 2);

        $display("scenario: held snooze button acts once");
        bus.alarm_do = 1'b0;
        cycles(1);
        bus.alarm_do = 1'b1;
        cycles(1);
        check("ring4.state", int'(bus.ring_state), 1);
        bus.down = 1'b1;
        cycles(20);
        check_state("held_down", 2, 1);
        for (int i = 0; i < 3; i++) sec_pulse();
        cycles(5);
        check_state("held_down_wake", 1, 1);
        bus.down = 1'b0;
        cycles(1);

        $display("scenario: reset during snooze with alarm held");
        bus.down = 1'b1;
        cycles(1);
        bus.down = 1'b0;
        check_state("snooze_pre_rst", 2, 0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_state("rst_abort", 0, 2);
        check("rst_abort.buzz", int'(bus.buzz), 0);
        cycles(1);
        check_state("post_rst_ring", 1, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameter TONE_DIV, default 25000, newclk cycles per buzz half-period.
REQ-002 Parameter RING_TIMEOUT, default 60, seconds ringing before auto-stop.
REQ-003 Parameter SNOOZE_SEC, default 300, seconds per snooze.
REQ-004 Parameter MAX_SNOOZE, default 3, snoozes per alarm event (1..7).
REQ-005 newclk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 alarm_do  in  1  alarm match level from the alarm block; its rising edge starts ringing.
REQ-008 sec_tick  in  1  one-cycle strobe, once per second.
REQ-009 middle  in  1  dismiss button, debounced level.
REQ-010 down  in  1  snooze button, debounced level.
REQ-011 buzz  out  1  square-wave tone to buzzer.
REQ-012 ring_state  out  2  0=IDLE, 1=RING, 2=SNOOZE.
REQ-013 snooze_left  out  3  snoozes remaining.

Function
REQ-014 SHALL rising-edge-detect alarm_do, middle and down against the previous cycle's registered value; a held level acts only once.
REQ-015 IDLE: trigger edge SHALL enter RING the next cycle, clear sec_cnt, reload snooze_left=MAX_SNOOZE.
REQ-016 RING: dismiss edge SHALL return to IDLE; else snooze edge with snooze_left>0 SHALL enter SNOOZE, decrement snooze_left, clear sec_cnt.
REQ-017 RING: snooze edge with snooze_left=0 SHALL be ignored.
REQ-018 RING: sec_cnt SHALL count sec_tick; on the tick making sec_cnt=RING_TIMEOUT, SHALL enter IDLE.
REQ-019 SNOOZE: dismiss edge SHALL enter IDLE; on the tick making sec_cnt=SNOOZE_SEC, SHALL enter RING with sec_cnt cleared.
REQ-020 Trigger edges in RING or SNOOZE SHALL be ignored; dismiss edge in IDLE SHALL be ignored.
REQ-021 Same-cycle priority SHALL be dismiss > snooze > timeout/sec_tick.
REQ-022 sec_cnt SHALL be 9 bits, saturating, never wrapping.
REQ-023 In RING, buzz SHALL toggle every TONE_DIV cycles while sec_cnt is even and be 0 while sec_cnt is odd (beep-pause at 1 Hz).
REQ-024 buzz SHALL be 0 in IDLE and SNOOZE; tone divider SHALL clear on every entry to RING so first beep begins with buzz=1 one TONE_DIV after entry.
REQ-025 All outputs SHALL be registered; latency from qualifying input edge to ring_state change is one cycle.

Reset
REQ-026 On rst: ring_state=IDLE, buzz=0, snooze_left=MAX_SNOOZE, sec_cnt=0, tone counter=0, edge-detect registers=current input levels' reset value 0.
REQ-027 rst asserted mid-RING or mid-SNOOZE SHALL abort to IDLE on that edge, overriding all other inputs.
REQ-028 After rst release, an alarm_do already high SHALL count as an edge (edge register reset to 0).

Structure
REQ-029 State encoding (IDLE/RING/SNOOZE) and parameter defaults SHALL live in shared package clock_pkg.
REQ-030 Rising-edge detection SHALL be one sub-module, edge_detect, instantiated three times.

Verification (TONE_DIV=2, RING_TIMEOUT=5, SNOOZE_SEC=3, MAX_SNOOZE=2)
REQ-031 alarm_do 0->1 at cycle 10 -> ring_state=1 at cycle 11, buzz=1 at cycle 13, toggling every 2 cycles until first sec_tick.
REQ-032 RING, 5 sec_ticks, no buttons -> ring_state=0 the cycle after 5th tick, buzz=0.
REQ-033 RING, down pulse -> SNOOZE, snooze_left=1; 3 ticks -> RING; down -> snooze_left=0; 3 ticks -> RING; down -> stays RING.
REQ-034 RING, middle and down rise same cycle -> IDLE, snooze_left=2.
REQ-035 down held high 20 cycles in RING -> exactly one snooze, snooze_left decremented once.
REQ-036 rst for 1 cycle during SNOOZE with alarm_do held 1 -> IDLE, then RING one cycle after rst release.
